// File: rtl/booth_divider.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, signs applied in FIX.
// Optional unsigned mode via BOOTH_DIVIDER_UNSIGNED_EN (adds input US).
module booth_divider #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
`ifdef BOOTH_DIVIDER_UNSIGNED_EN
  input  logic           US,
`endif
  input  logic           S,
  input  logic [2*W-1:0] IN1,
  input  logic [W-1:0]   IN2,
  output logic           f,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem,
  output logic           dz,
  output logic           ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(2*W);
  localparam logic [CW-1:0] LAST_ITER = CW'(2*W-1);
  localparam logic [W-1:0]  QMIN_MAG  = {1'b1, {(W-1){1'b0}}};

  function automatic logic [2*W-1:0] cond_neg_wide(input logic [2*W-1:0] v, input logic neg);
    cond_neg_wide = neg ? (~v + (2*W)'(1)) : v;
  endfunction

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    cond_neg = neg ? (~v + W'(1)) : v;
  endfunction

  logic [1:0]     state_r;
  logic [2*W-1:0] dvd_r;
  logic [W-1:0]   dvs_r;
  logic [W-1:0]   prem_r;
  logic [CW-1:0]  cnt_r;
  logic           s1_r;
  logic           s2_r;
  logic           us_r;
  logic           f_r;
  logic [W-1:0]   quot_r;
  logic [W-1:0]   rem_r;
  logic           dz_r;
  logic           ovf_r;

  logic           us_s;
  logic           in1_neg_s;
  logic           in2_neg_s;
  logic [W:0]     shl_s;
  logic [W:0]     diff_s;
  logic           borrow_s;
  logic           take_s;
  logic           negq_s;
  logic           ovf_s;
  logic [W-1:0]   quot_s;
  logic [W-1:0]   rem_s;

`ifdef BOOTH_DIVIDER_UNSIGNED_EN
  assign us_s = US;
`else
  assign us_s = 1'b0;
`endif

  assign in1_neg_s = IN1[2*W-1] & ~us_s;
  assign in2_neg_s = IN2[W-1] & ~us_s;

  // Trial subtraction for one iteration plus the sign/overflow fix-up of the final magnitudes.
  always_comb begin
    shl_s             = {prem_r, dvd_r[2*W-1]};
    {borrow_s, diff_s} = {1'b0, shl_s} - {2'b00, dvs_r};
    // A kept difference is always below the divisor, so diff_s[W] set can only mean a borrow
    take_s            = ~(borrow_s | diff_s[W]);
    negq_s            = s1_r ^ s2_r;
    if (us_r) begin
      ovf_s = |dvd_r[2*W-1:W];
    end else if (negq_s) begin
      ovf_s = (|dvd_r[2*W-1:W]) | (dvd_r[W-1:0] > QMIN_MAG);
    end else begin
      ovf_s = (|dvd_r[2*W-1:W]) | dvd_r[W-1];
    end
    quot_s = cond_neg(dvd_r[W-1:0], negq_s);
    rem_s  = cond_neg(prem_r, s1_r);
  end

  // Control FSM, datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      dvd_r   <= '0;
      dvs_r   <= '0;
      prem_r  <= '0;
      cnt_r   <= '0;
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      us_r    <= 1'b0;
      f_r     <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (S) begin
            if (IN2 == W'(0)) begin
              dz_r    <= 1'b1;
              ovf_r   <= 1'b0;
              quot_r  <= '0;
              rem_r   <= '0;
              state_r <= DONE;
            end else begin
              dvd_r   <= cond_neg_wide(IN1, in1_neg_s);
              dvs_r   <= cond_neg(IN2, in2_neg_s);
              s1_r    <= in1_neg_s;
              s2_r    <= in2_neg_s;
              us_r    <= us_s;
              prem_r  <= '0;
              cnt_r   <= '0;
              dz_r    <= 1'b0;
              ovf_r   <= 1'b0;
              state_r <= DIV;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DIV: begin
          prem_r <= take_s ? diff_s[W-1:0] : shl_s[W-1:0];
          dvd_r  <= {dvd_r[2*W-2:0], take_s};
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == LAST_ITER) begin
            state_r <= FIX;
          end else begin
            state_r <= DIV;
          end
        end
        FIX: begin
          ovf_r   <= ovf_s;
          quot_r  <= ovf_s ? W'(0) : quot_s;
          rem_r   <= ovf_s ? W'(0) : rem_s;
          f_r     <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          // The divide-by-zero path arrives with f still low and raises it one edge later
          if (!f_r) begin
            f_r <= 1'b1;
          end else if (!S) begin
            f_r     <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          f_r     <= 1'b0;
        end
      endcase
    end
  end

  assign f    = f_r;
  assign quot = quot_r;
  assign rem  = rem_r;
  assign dz   = dz_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider (W=8, signed build).
module tb_booth_divider;

  logic        clk;
  logic        rst;
  logic        S;
  logic [15:0] IN1;
  logic [7:0]  IN2;
  logic        f;
  logic [7:0]  quot;
  logic [7:0]  rem;
  logic        dz;
  logic        ovf;

  int checks;
  int failures;

  booth_divider #(.W(8)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef BOOTH_DIVIDER_UNSIGNED_EN
    .US   (1'b0),
`endif
    .S    (S),
    .IN1  (IN1),
    .IN2  (IN2),
    .f    (f),
    .quot (quot),
    .rem  (rem),
    .dz   (dz),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launch one division with an S pulse, scramble the inputs while busy, then check the result.
  task automatic run(input string tag, input logic [15:0] a, input logic [7:0] b,
                     input int lat, input logic [7:0] eq, input logic [7:0] er,
                     input logic edz, input logic eovf);
    int n;
    @(negedge clk);
    IN1 = a;
    IN2 = b;
    S   = 1'b1;
    @(posedge clk);
    #1;
    S   = 1'b0;
    IN1 = ~a;
    IN2 = 8'h00;
    n   = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (f) break;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_quot"}, quot, eq);
    chk({tag, "_rem"}, rem, er);
    chk({tag, "_dz"}, dz, edz);
    chk({tag, "_ovf"}, ovf, eovf);
    @(posedge clk);
    #1;
    chk({tag, "_fdrop"}, f, 1'b0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    S   = 1'b0;
    IN1 = 16'h0000;
    IN2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f", f, 1'b0);
    chk("rst_quot", quot, 8'h00);
    chk("rst_rem", rem, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    run("pp",    16'd100, 8'd7,  17, 8'h0E, 8'h02, 1'b0, 1'b0);
    run("np",    16'hFF9C, 8'd7, 17, 8'hF2, 8'hFE, 1'b0, 1'b0);
    run("pn",    16'd100, 8'hF9, 17, 8'hF2, 8'h02, 1'b0, 1'b0);
    run("dz",    16'd55,  8'd0,   1, 8'h00, 8'h00, 1'b1, 1'b0);
    run("min",   16'hFF80, 8'd1, 17, 8'h80, 8'h00, 1'b0, 1'b0);
    run("pos128",16'd128, 8'd1,  17, 8'h00, 8'h00, 1'b0, 1'b1);
    run("ovf1k", 16'd1000, 8'd7, 17, 8'h00, 8'h00, 1'b0, 1'b1);
    run("max",   16'd127, 8'd1,  17, 8'h7F, 8'h00, 1'b0, 1'b0);
    run("nn",    16'hFF9C, 8'hF9, 17, 8'h0E, 8'hFE, 1'b0, 1'b0);

    // Abort at iteration 5 with an asynchronous reset between edges.
    @(negedge clk);
    IN1 = 16'd100;
    IN2 = 8'd7;
    S   = 1'b1;
    @(posedge clk);
    #1;
    S = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_f", f, 1'b0);
    chk("abort_quot", quot, 8'h00);
    chk("abort_rem", rem, 8'h00);
    chk("abort_dz", dz, 1'b0);
    chk("abort_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", 16'd50, 8'd3, 17, 8'h10, 8'h02, 1'b0, 1'b0);

    // Hold S high through DONE: no restart, outputs stable.
    @(negedge clk);
    IN1 = 16'd50;
    IN2 = 8'd3;
    S   = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (f) break;
    end
    chk("hold_lat", n, 17);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_f", f, 1'b1);
      chk("hold_quot", quot, 8'h10);
      chk("hold_rem", rem, 8'h02);
    end
    @(negedge clk);
    S = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_fdrop", f, 1'b0);
    chk("hold_keep_quot", quot, 8'h10);
    @(posedge clk);
    #1;
    chk("hold_idle_f", f, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
